// File: rtl/mem_bus_master_if.sv
// Request/acknowledge memory bus between the CPU memory port and a
// variable-latency responder.
interface mem_bus_master_if #(
  parameter int ADDR_W = 9
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_bus_master.sv
// Multi-cycle CPU memory-port initiator: IDLE -> REQ -> DONE handshake feeding IR/MDR.
// Optional request timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_bus_master #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic [31:0] PC,
  input  logic [31:0] ALUOut,
  input  logic [31:0] wdata,
  output logic [31:0] IR,
  output logic [31:0] MDR,
  output logic        busy,
  output logic        done,
  output logic        err,
  mem_bus_master_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ir_sel_q, ir_sel_d;
  logic              done_q, done_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Upper address bits are intentionally dropped by the bus width.
  logic unused_bits;
`ifdef MEM_TIMEOUT_EN
  assign unused_bits = ^{PC[31:ADDR_W], ALUOut[31:ADDR_W]};
`else
  assign unused_bits = ^{PC[31:ADDR_W], ALUOut[31:ADDR_W], TIMEOUT[0]};
`endif

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ir_sel_d = ir_sel_q;
    done_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (MemWrite || MemRead) begin
          addr_d   = IorD ? ALUOut[ADDR_W-1:0] : PC[ADDR_W-1:0];
          we_d     = MemWrite;
          wdata_d  = wdata;
          ir_sel_d = IRWrite & ~MemWrite;
          req_d    = 1'b1;
          state_d  = S_REQ;
`ifdef MEM_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      S_REQ: begin
        if (bus.bus_ack) begin
          if (!we_q) begin
            mdr_d = bus.bus_rdata;
            if (ir_sel_q) ir_d = bus.bus_rdata;
          end
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        // Ack is tested first so a same-cycle ack beats the abort.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      mdr_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ir_sel_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ir_sel_q <= ir_sel_d;
      done_q   <= done_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign IR            = ir_q;
  assign MDR           = mdr_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
`ifdef MEM_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

CPU-side initiator for the multi-cycle datapath's memory port. Accepts the control unit's MemRead/MemWrite/IorD/IRWrite strobes and runs a request/acknowledge transaction on a variable-latency memory bus. It returns read data into the instruction register (IR) and the memory data register (MDR), and holds `busy` so the control FSM stalls until the access completes. It replaces direct RAM wiring so that memories with wait states can sit behind the port.

## Interface
- `ADDR_W`, default 9: bus address width; low ADDR_W bits of the selected 32-bit address.
- `TIMEOUT`, default 15: maximum REQ cycles without ack before abort (only with MEM_TIMEOUT_EN).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `MemRead` in 1: read command from the control unit.
- `MemWrite` in 1: write command from the control unit.
- `IorD` in 1: address select; 0 selects PC, 1 selects ALUOut.
- `IRWrite` in 1: on a read, also load the returned word into IR.
- `PC` in 32: instruction address.
- `ALUOut` in 32: data address.
- `wdata` in 32: store data.
- `IR` out 32: instruction register.
- `MDR` out 32: memory data register.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when a transaction completes.
- `err` out 1: one-cycle pulse on timeout abort.
- `bus_req` out 1: request, held until ack.
- `bus_we` out 1: 1 = write, 0 = read.
- `bus_addr` out ADDR_W: transaction address.
- `bus_wdata` out 32: write data.
- `bus_ack` in 1: responder acknowledge; read data is valid in the same cycle.
- `bus_rdata` in 32: read data.

## Operation
- States: IDLE, REQ, DONE. All outputs are registered.
- IDLE:
  - If MemWrite or MemRead is high, latch the command: bus_addr = (IorD ? ALUOut : PC)[ADDR_W-1:0], bus_we = MemWrite, bus_wdata = wdata, ir_sel = IRWrite & ~MemWrite. Go to REQ.
  - MemWrite has priority when both strobes are high; the read is dropped.
- REQ:
  - bus_req = 1, and bus_addr/bus_we/bus_wdata stay stable.
  - On bus_ack = 1 with a read: MDR ← bus_rdata, and IR ← bus_rdata if ir_sel is set. Go to DONE.
  - On bus_ack = 1 with a write: IR and MDR are unchanged. Go to DONE.
- DONE: done = 1 and bus_req = 0. Go to IDLE unconditionally. Commands presented in DONE are ignored.
- bus_ack is ignored outside REQ.
- Command strobes and IorD/PC/ALUOut/wdata are sampled only in IDLE. Changes during REQ have no effect.
- The control unit must deassert its strobes in the cycle after it samples done = 1. Strobes still high in IDLE start a new transaction.
- IR and MDR otherwise hold their value. There is no combinational path from bus_rdata to IR or MDR.

## Timing
- Reset values: state IDLE; IR = 0, MDR = 0, bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, busy = 0, done = 0, err = 0; timeout counter 0.
- Command sampled at edge 0. bus_req is high from cycle 1.
- Ack in cycle k ≥ 1: IR/MDR are updated and done = 1 in cycle k+1, and the block is IDLE in cycle k+2.
- Minimum command-to-done latency is 2 cycles.
- busy is high from cycle 1 through the done cycle inclusive.
- Reset has priority over every other event. rst asserted mid-REQ drops bus_req on the next edge, discards the transaction, and zeroes IR and MDR.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter reaches TIMEOUT with no ack: drop bus_req, pulse err for one cycle, go straight to IDLE. done is not pulsed and IR/MDR are unchanged.
  - An ack in the same cycle the count reaches TIMEOUT wins, and the transaction completes normally.
- `MEM_TIMEOUT_EN` undefined: there is no counter, err is tied to 0, and REQ waits indefinitely for ack.

## Test plan
- Instruction fetch: IorD = 0, PC = 0x0000_0010, MemRead = 1, IRWrite = 1; responder acks in cycle 1 with 0x8C22_0004 → bus_addr = 0x010 and bus_we = 0; IR = MDR = 0x8C22_0004 with done = 1 in cycle 2; busy = 0 in cycle 3.
- Load with 3 wait states: IorD = 1, ALUOut = 0x0000_0044, MemRead = 1, IRWrite = 0; ack in cycle 4 with 0xDEAD_BEEF → bus_addr = 0x044; bus_req high in cycles 1–4; MDR = 0xDEAD_BEEF, IR unchanged, done = 1 in cycle 5.
- Store with simultaneous strobes: MemRead = MemWrite = 1, ALUOut = 0x0000_0080, wdata = 0x1234_5678 → bus_we = 1, bus_wdata = 0x1234_5678, bus_addr = 0x080; after ack, IR and MDR are unchanged.
- Spurious ack and mid-transaction reset: bus_ack = 1 while IDLE → no change. Then start a read and assert rst in cycle 2 of REQ → bus_req = 0, IR = MDR = 0, state IDLE next cycle; a later ack is ignored.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT = 15): read with no ack → err = 1 for exactly one cycle after 15 REQ cycles, done never pulses, MDR unchanged. Repeat with ack on the 15th REQ cycle → done = 1 and err = 0.
